// File: rtl/mem_arb_pkg.sv
// Shared encodings and the response-stage record for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic       we;
    logic       err;
    size_e      size;
    logic [1:0] off;
    logic       uns;
  } rsp_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic for the load/store port: store BE and lane replication, load
// extraction with sign/zero extension, and the alignment check. Purely combinational.
module lsu_lane_align
  import mem_arb_pkg::*;
(
  input  size_e       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        misalign_o,
  input  size_e       ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0;
    misalign_o = 1'b0;
    case (st_size_i)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_wdata_i[15:0]}};
        misalign_o = st_off_i[0];
      end
      SZ_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        misalign_o = |st_off_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte   = ld_rdata_i[8*ld_off_i +: 8];
    ld_half   = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    ld_data_o = 32'h0;
    case (ld_size_i)
      SZ_BYTE: ld_data_o = {{24{~ld_unsigned_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{~ld_unsigned_i & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data_o = ld_rdata_i;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-enabled word port between instruction fetch and load/store,
// with LS priority bounded by a streak counter and a single registered response stage.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES     = 'h40_0000,
  parameter int unsigned MAX_LS_STREAK = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  rsp_t          rsp_q, rsp_d;

  size_e       ls_size;
  logic        ls_misalign, ls_err, if_err;
  logic        ls_gnt, if_gnt;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign ls_size = size_e'(ls_size_i);

  lsu_lane_align u_lane (
    .st_size_i     (ls_size),
    .st_off_i      (ls_addr_i[1:0]),
    .st_wdata_i    (ls_wdata_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .misalign_o    (ls_misalign),
    .ld_size_i     (rsp_q.size),
    .ld_off_i      (rsp_q.off),
    .ld_unsigned_i (rsp_q.uns),
    .ld_rdata_i    (mem_rdata_i),
    .ld_data_o     (ld_data)
  );

  assign ls_err = ls_misalign | (ls_addr_i >= MEM_BYTES);
  assign if_err = (|if_addr_i[1:0]) | (if_addr_i >= MEM_BYTES);

  // Grants are masked by reset so nothing reaches memory while reset is held.
  assign ls_gnt = ~rst_i & ls_req_i & ~(if_req_i & (streak_q == STREAK_MAX));
  assign if_gnt = ~rst_i & if_req_i & ~ls_gnt;
  assign ls_gnt_o = ls_gnt;
  assign if_gnt_o = if_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (ls_gnt && !ls_err) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_addr_o  = {ls_addr_i[31:2], 2'b00};
      mem_be_o    = ls_we_i ? st_be : 4'b1111;
      mem_wdata_o = ls_we_i ? st_wdata : 32'h0;
    end else if (if_gnt && !if_err) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {if_addr_i[31:2], 2'b00};
      mem_be_o   = 4'b1111;
    end
  end

  always_comb begin
    rsp_d = '0;
    if (ls_gnt) begin
      rsp_d.valid = 1'b1;
      rsp_d.owner = OWN_LS;
      rsp_d.we    = ls_we_i;
      rsp_d.err   = ls_err;
      rsp_d.size  = ls_size;
      rsp_d.off   = ls_addr_i[1:0];
      rsp_d.uns   = ls_unsigned_i;
    end else if (if_gnt) begin
      rsp_d.valid = 1'b1;
      rsp_d.owner = OWN_IF;
      rsp_d.err   = if_err;
      rsp_d.size  = SZ_WORD;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && streak_q != STREAK_MAX) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state uses non-blocking assignment; async reset also drops any in-flight response.
    if (rst_i) begin
      streak_q <= '0;
      rsp_q    <= '0;
    end else begin
      streak_q <= streak_d;
      rsp_q    <= rsp_d;
    end
  end

  assign if_rvalid_o = rsp_q.valid & (rsp_q.owner == OWN_IF);
  assign ls_rvalid_o = rsp_q.valid & (rsp_q.owner == OWN_LS);
  assign if_err_o    = if_rvalid_o & rsp_q.err;
  assign ls_err_o    = ls_rvalid_o & rsp_q.err;
  assign if_rdata_o  = (if_rvalid_o & ~rsp_q.err) ? mem_rdata_i : 32'h0;
  assign ls_rdata_o  = (ls_rvalid_o & ~rsp_q.err & ~rsp_q.we) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural word memory plus a response scoreboard
// filled at grant time and drained one cycle later.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_unsigned_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_ls;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [logic [29:0]];

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MEM_BYTES('h40_0000), .MAX_LS_STREAK(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_unsigned_i(ls_unsigned_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_err_o(ls_err_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
  endfunction

  // Write-first word memory with a one-cycle read.
  always @(posedge clk_i) begin
    logic [31:0] w;
    if (mem_en_o) begin
      w = mem.exists(mem_addr_o[31:2]) ? mem[mem_addr_o[31:2]] : mem_init(mem_addr_o);
      if (mem_we_o) begin
        for (int i = 0; i < 4; i++) if (mem_be_o[i]) w[8*i +: 8] = mem_wdata_o[8*i +: 8];
        mem[mem_addr_o[31:2]] = w;
      end else begin
        mem_rdata_i <= w;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, ~e.is_ls});
      check("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, e.is_ls});
      check(e.is_ls ? "ls_rdata" : "if_rdata", e.is_ls ? ls_rdata_o : if_rdata_o, e.rdata);
      check(e.is_ls ? "ls_err" : "if_err", {31'b0, e.is_ls ? ls_err_o : if_err_o}, {31'b0, e.err});
    end else begin
      check("no_rvalid", {30'b0, if_rvalid_o, ls_rvalid_o}, 32'h0);
    end
  endtask

  task automatic ls_step(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
    if_req_i = 1'b0; ls_req_i = 1'b1; ls_we_i = we; ls_size_i = size;
    ls_unsigned_i = uns; ls_addr_i = addr; ls_wdata_i = wdata;
    @(negedge clk_i);
    check_resp();
    check("ls_gnt", {31'b0, ls_gnt_o}, 32'h1);
    check("if_gnt", {31'b0, if_gnt_o}, 32'h0);
    check("mem_en", {31'b0, mem_en_o}, {31'b0, ~err});
    if (!err) begin
      check("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
      check("mem_we", {31'b0, mem_we_o}, {31'b0, we});
      if (we) begin
        check("mem_be", {28'b0, mem_be_o}, {28'b0, exp_be});
        check("mem_wdata", mem_wdata_o, exp_wdata);
      end
    end
    exp_q.push_back('{1'b1, exp_rdata, err});
    @(posedge clk_i); #1;
    ls_req_i = 1'b0;
  endtask

  task automatic if_step(input logic [31:0] addr, input logic err, input logic [31:0] exp_rdata);
    ls_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = addr;
    @(negedge clk_i);
    check_resp();
    check("if_gnt", {31'b0, if_gnt_o}, 32'h1);
    check("mem_en", {31'b0, mem_en_o}, {31'b0, ~err});
    if (!err) check("mem_be", {28'b0, mem_be_o}, 32'hF);
    exp_q.push_back('{1'b0, exp_rdata, err});
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
  endtask

  task automatic idle_step();
    if_req_i = 1'b0; ls_req_i = 1'b0;
    @(negedge clk_i);
    check_resp();
    check("idle_gnt", {30'b0, if_gnt_o, ls_gnt_o}, 32'h0);
    check("idle_mem", {mem_en_o, mem_we_o, mem_be_o} | mem_addr_o | mem_wdata_o, 32'h0);
    @(posedge clk_i); #1;
  endtask

  // Both requesters active each cycle; exp_ls gives the expected winner.
  task automatic both_step(input logic exp_ls);
    if_req_i = 1'b1; if_addr_i = 32'h200;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h20_0000;
    @(negedge clk_i);
    check_resp();
    check("arb_winner", {30'b0, if_gnt_o, ls_gnt_o}, exp_ls ? 32'h1 : 32'h2);
    exp_q.push_back('{exp_ls, exp_ls ? 32'h1234_80EF : mem_init(32'h200), 1'b0});
    @(posedge clk_i); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {20'b0, if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o,
          ls_err_o, mem_en_o, mem_we_o, mem_be_o}, 32'h0);
    check({tag, "_data"}, if_rdata_o | ls_rdata_o | mem_addr_o | mem_wdata_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_size_i = 2'b00; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h0; ls_wdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("post_reset");
    @(posedge clk_i); #1;

    // Stores and loads with lane alignment and extension.
    ls_step(1, 2'b10, 0, 32'h20_0000, 32'hDEAD_BEEF, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    ls_step(0, 2'b00, 0, 32'h20_0001, 32'h0, 0, 32'hFFFF_FFBE, 4'h0, 32'h0);
    ls_step(0, 2'b00, 1, 32'h20_0001, 32'h0, 0, 32'h0000_00BE, 4'h0, 32'h0);
    ls_step(1, 2'b01, 0, 32'h20_0002, 32'hABCD_1234, 0, 32'h0, 4'b1100, 32'h1234_1234);
    ls_step(0, 2'b01, 0, 32'h20_0002, 32'h0, 0, 32'h0000_1234, 4'h0, 32'h0);
    ls_step(0, 2'b01, 0, 32'h20_0000, 32'h0, 0, 32'hFFFF_BEEF, 4'h0, 32'h0);
    ls_step(1, 2'b00, 0, 32'h20_0001, 32'hFFFF_FF80, 0, 32'h0, 4'b0010, 32'h8080_8080);
    ls_step(0, 2'b00, 0, 32'h20_0001, 32'h0, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
    ls_step(0, 2'b10, 0, 32'h20_0000, 32'h0, 0, 32'h1234_80EF, 4'h0, 32'h0);
    ls_step(0, 2'b00, 1, 32'h20_0003, 32'h0, 0, 32'h0000_0012, 4'h0, 32'h0);
    idle_step();
    if_step(32'h100, 0, mem_init(32'h100));

    // Error paths: misalignment, illegal size, out of range.
    ls_step(0, 2'b10, 0, 32'h20_0002, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    if_step(32'h40_0000, 1, 32'h0);
    if_step(32'h102, 1, 32'h0);
    ls_step(0, 2'b01, 0, 32'h20_0001, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    ls_step(0, 2'b11, 0, 32'h20_0000, 32'h0, 1, 32'h0, 4'h0, 32'h0);
    ls_step(1, 2'b10, 0, 32'h40_0000, 32'hFFFF_FFFF, 1, 32'h0, 4'h0, 32'h0);
    ls_step(0, 2'b10, 0, 32'h3F_FFFC, 32'h0, 0, mem_init(32'h3F_FFFC), 4'h0, 32'h0);
    idle_step();

    // Fairness: LS, LS, IF repeating under continuous contention.
    for (int i = 0; i < 7; i++) both_step((i % 3) != 2);
    idle_step();
    // A cycle with IF idle clears the streak.
    both_step(1'b1);
    ls_step(0, 2'b10, 0, 32'h20_0000, 32'h0, 0, 32'h1234_80EF, 4'h0, 32'h0);
    both_step(1'b1);
    both_step(1'b1);
    both_step(1'b0);
    idle_step();

    // Reset in the cycle after a load grant drops its response and blocks writes.
    ls_step(0, 2'b10, 0, 32'h20_0000, 32'h0, 0, 32'h1234_80EF, 4'h0, 32'h0);
    rst_i = 1'b1;
    exp_q.delete();
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_size_i = 2'b10; ls_addr_i = 32'h20_0000;
    ls_wdata_i = 32'h0; if_req_i = 1'b1; if_addr_i = 32'h0;
    @(negedge clk_i);
    check_all_zero("in_reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0; ls_req_i = 1'b0; if_req_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("after_reset");
    @(posedge clk_i); #1;
    if_step(32'h20_0000, 0, 32'h1234_80EF);
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
